mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the core's instruction-fetch and data (load/store) requests onto a single unified memory port, letting the core run against one shared memory of variable latency. It sits between the core's fetch/data request interfaces and the memory, and stalls each requester until its access completes. It applies round-robin arbitration, holds one outstanding access at a time, and can optionally abort accesses whose memory response never arrives.

## Interface
Parameters:
- XLEN, 32, data/address width
- TIMEOUT_CYCLES, 64, max cycles an access may wait for mem_ready (used only with MEM_ARB_TIMEOUT_EN)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  XLEN  fetch address
- if_ack  out  1  one-cycle completion pulse; if_rdata valid this cycle
- if_rdata  out  XLEN  fetched word
- if_err  out  1  pulse with if_ack when the access timed out
- d_req  in  1  data request; held with all d_* fields stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_width  in  3  funct3 size code
- d_ack  out  1  one-cycle completion pulse; d_rdata valid this cycle
- d_rdata  out  XLEN  load data
- d_err  out  1  pulse with d_ack when the access timed out
- mem_req  out  1  memory request; held with fields stable until mem_ready
- mem_we, mem_addr, mem_wdata, mem_width  out  1/XLEN/XLEN/3  access fields
- mem_rdata  in  XLEN  read data, valid when mem_ready
- mem_ready  in  1  completion; sampled only while mem_req=1
- timeout_err  out  1  sticky flag; set on any timeout, cleared only by reset

## Operation
- States: ARB_IDLE, ARB_IFETCH, ARB_DATA.
- Arbitration point: in ARB_IDLE, and in the completion cycle of a BUSY state (mem_ready=1).
- Arbitration rule: only one request pending → grant it. Both pending → grant the requester not served last (last_grant pointer).
- The completing requester is excluded from arbitration in its own completion cycle, because its req is still high.
- No request pending → ARB_IDLE.
- ARB_IFETCH drives mem_addr=if_addr, mem_we=0, mem_width=3'b010, mem_wdata=0.
- ARB_DATA passes the d_* fields straight through to mem_*.
- mem_req=1 in both BUSY states. mem_* fields are 0 in ARB_IDLE.
- Completion: mem_ready=1 in a BUSY state → granted requester's ack=1 and rdata=mem_rdata, combinationally in the same cycle. rdata is 0 when ack=0.
- last_grant updates on each grant.
- Reset values: state=ARB_IDLE; last_grant=DATA, so IFETCH wins the first tie; all outputs 0; timeout_err=0.
- mem_req, if_ack and d_ack are forced to 0 while reset=1.
- Reset mid-access abandons the access without an ack. Requesters must re-issue after reset.

## Timing
- Request seen in ARB_IDLE at cycle N → state BUSY at N+1, mem_req=1 at N+1.
- mem_ready at N+1+k → ack at N+1+k. Minimum latency is 1 cycle from the grant register.
- Back-to-back with mem_ready tied 1 and both requesting: alternating grants, one ack per cycle, no ARB_IDLE cycles.
- mem_ready while mem_req=0 is ignored.
- if_ack and d_ack never assert in the same cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on each grant and increments each BUSY cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES, mem_req drops that cycle. The requester gets ack=1, err=1, rdata=0, and timeout_err sets.
  - Arbitration then proceeds as for a normal completion.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, err=0.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter; accesses wait indefinitely.
  - if_err, d_err and timeout_err are tied 0.
  - TIMEOUT_CYCLES is unused.

## Structure
- The shared core package holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_IFETCH, ARB_DATA}
  - typedef enum requester_t {REQ_IF, REQ_D}
  - the constant WIDTH_WORD=3'b010
- Sub-module arb_timeout_ctr (parameter TIMEOUT_CYCLES; inputs clr, inc; output expired):
  - instantiated only under MEM_ARB_TIMEOUT_EN
  - counter width is $clog2(TIMEOUT_CYCLES+1)

## Test plan
- Reset, then if_req=1 with if_addr=0x100 and mem_ready=1 → mem_req=1 with mem_addr=0x100, width 3'b010 next cycle; if_ack with if_rdata=mem_rdata=0xDEADBEEF in that same cycle.
- if_req and d_req both 1 from ARB_IDLE, mem_ready tied 1 → grant order IF, D, IF, D; one ack per cycle; never both acks high.
- d_req store, d_addr=0x10, d_wdata=0x55, d_width=3'b000, mem_ready delayed 3 cycles → mem_* fields stable for 4 cycles; d_ack on the 4th.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 → d_ack=1, d_err=1, d_rdata=0 on the 4th BUSY cycle; timeout_err stays 1 until reset.
- Reset asserted during ARB_DATA with mem_ready=0 → mem_req=0 the same cycle; no d_ack; state ARB_IDLE after the edge.
- mem_ready=1 pulsed while idle → no ack, state unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DATA   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } requester_t;

  localparam logic [2:0] WIDTH_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_timeout_ctr.sv
// Wait counter that flags an access stuck without mem_ready.
// Only built when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (inc)
      r_count <= r_count + 1'b1;
  end

  // Expires in the cycle whose increment would make the count reach the limit.
  assign expired = inc && ((int'(r_count) + 1) >= TIMEOUT_CYCLES);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of instruction-fetch and data requests onto one memory port.
// Define MEM_ARB_TIMEOUT_EN to abort accesses that never see mem_ready.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [2:0]      d_width,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_width,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            timeout_err
);

  arb_state_t r_state, w_nextState;
  requester_t r_lastGrant, w_grantTo;
  logic       w_busy, w_expired, w_done, w_ifCand, w_dCand, w_grant;

  assign w_busy = (r_state != ARB_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  logic w_inc;
  logic r_timeoutErr;

  assign w_inc = w_busy && !mem_ready;

  arb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_grant),
    .inc     (w_inc),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_timeoutErr <= 1'b0;
    else if (w_expired)
      r_timeoutErr <= 1'b1;
  end

  assign timeout_err = r_timeoutErr;
  assign if_err      = if_ack && !mem_ready;
  assign d_err       = d_ack && !mem_ready;
`else
  assign w_expired   = 1'b0;
  assign timeout_err = 1'b0;
  assign if_err      = 1'b0;
  assign d_err       = 1'b0;
`endif

  assign w_done = w_busy && (mem_ready || w_expired);

  // A requester finishing this cycle still holds req high, so it sits out this arbitration.
  assign w_ifCand = if_req && !(w_done && r_state == ARB_IFETCH);
  assign w_dCand  = d_req  && !(w_done && r_state == ARB_DATA);

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_grantTo   = r_lastGrant;
    if (!w_busy || w_done) begin
      w_nextState = ARB_IDLE;
      if (w_ifCand && (!w_dCand || r_lastGrant == REQ_D)) begin
        w_nextState = ARB_IFETCH;
        w_grant     = 1'b1;
        w_grantTo   = REQ_IF;
      end else if (w_dCand) begin
        w_nextState = ARB_DATA;
        w_grant     = 1'b1;
        w_grantTo   = REQ_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_lastGrant <= REQ_D;
    end else begin
      r_state <= w_nextState;
      if (w_grant)
        r_lastGrant <= w_grantTo;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = 3'b000;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (r_state)
      ARB_IFETCH: begin
        mem_req   = !w_expired;
        mem_addr  = if_addr;
        mem_width = WIDTH_WORD;
        if_ack    = w_done;
      end
      ARB_DATA: begin
        mem_req   = !w_expired;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_width = d_width;
        d_ack     = w_done;
      end
      default: ;
    endcase
    // Reset abandons any access immediately, without an ack.
    if (reset) begin
      mem_req = 1'b0;
      if_ack  = 1'b0;
      d_ack   = 1'b0;
    end
  end

  assign if_rdata = (if_ack && mem_ready) ? mem_rdata : '0;
  assign d_rdata  = (d_ack && mem_ready) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized traffic vs. a transaction model.
// Define MEM_ARB_TIMEOUT_EN to also exercise the timeout feature (TIMEOUT_CYCLES=4).
module tb_mem_arbiter;

  localparam int XLEN = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TC = 4;
`else
  localparam int TC = 64;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ack;
  logic [XLEN-1:0] if_rdata;
  logic            if_err;
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [2:0]      d_width;
  logic            d_ack;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [2:0]      mem_width;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            timeout_err;

  mem_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic dReq, input logic dWe, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [2:0] dWidth,
                               input logic memReady, input logic [31:0] memRdata);
    if_req    = ifReq;
    if_addr   = ifAddr;
    d_req     = dReq;
    d_we      = dWe;
    d_addr    = dAddr;
    d_wdata   = dWdata;
    d_width   = dWidth;
    mem_ready = memReady;
    mem_rdata = memRdata;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  // Transaction-level model: who owns the port, who was served last, how long we've waited.
  int owner      = 0;   // 0 none, 1 fetch, 2 data
  int lastServed = 2;
  int waitCnt    = 0;
  bit stickyErr  = 1'b0;

  bit          mBusy, mExpired, mDone, mIfWants, mDWants;
  bit          eIfAck, eDAck;
  int          pick;
  logic [31:0] eAddr, eWdata;
  logic [2:0]  eWidth;
  logic        eWe;

  always @(negedge clk) begin : compare
    mBusy    = (owner != 0);
    mExpired = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    mExpired = mBusy && !mem_ready && (waitCnt + 1 >= TC);
`endif
    mDone  = mBusy && (mem_ready || mExpired);
    eIfAck = (owner == 1) && mDone && !reset;
    eDAck  = (owner == 2) && mDone && !reset;
    eAddr  = 0; eWdata = 0; eWidth = 3'b000; eWe = 1'b0;
    if (owner == 1) begin
      eAddr = if_addr; eWidth = 3'b010;
    end else if (owner == 2) begin
      eAddr = d_addr; eWdata = d_wdata; eWidth = d_width; eWe = d_we;
    end

    checkOutput("mem_req",     mem_req,     mBusy && !mExpired && !reset);
    checkOutput("mem_we",      mem_we,      eWe);
    checkOutput("mem_addr",    mem_addr,    eAddr);
    checkOutput("mem_wdata",   mem_wdata,   eWdata);
    checkOutput("mem_width",   mem_width,   eWidth);
    checkOutput("if_ack",      if_ack,      eIfAck);
    checkOutput("d_ack",       d_ack,       eDAck);
    checkOutput("if_rdata",    if_rdata,    (eIfAck && mem_ready) ? mem_rdata : 32'h0);
    checkOutput("d_rdata",     d_rdata,     (eDAck && mem_ready) ? mem_rdata : 32'h0);
    checkOutput("if_err",      if_err,      eIfAck && mExpired);
    checkOutput("d_err",       d_err,       eDAck && mExpired);
    checkOutput("timeout_err", timeout_err, stickyErr);
    checkOutput("acks_exclusive", if_ack && d_ack, 1'b0);

    if (reset) begin
      owner = 0; lastServed = 2; waitCnt = 0; stickyErr = 1'b0;
    end else begin
      if (mExpired) stickyErr = 1'b1;
      if (mBusy && !mem_ready) waitCnt++;
      if (!mBusy || mDone) begin
        mIfWants = if_req && !(mDone && owner == 1);
        mDWants  = d_req  && !(mDone && owner == 2);
        if (mIfWants && mDWants) pick = (lastServed == 1) ? 2 : 1;
        else if (mIfWants)       pick = 1;
        else if (mDWants)        pick = 2;
        else                     pick = 0;
        owner = pick;
        if (pick != 0) begin
          lastServed = pick;
          waitCnt    = 0;
        end
      end
    end
  end

  bit sawIf, sawD;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 1'b0);
    checkOutput("rst_if_ack", if_ack, 1'b0);
    checkOutput("rst_d_ack", d_ack, 1'b0);
    checkOutput("rst_timeout_err", timeout_err, 1'b0);
    nextCycle();
    reset = 1'b0;

    // Single fetch with an immediately ready memory.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 3'b000, 1, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("fetch_idle_req", mem_req, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("fetch_mem_req", mem_req, 1'b1);
    checkOutput("fetch_mem_addr", mem_addr, 32'h100);
    checkOutput("fetch_mem_width", mem_width, 3'b010);
    checkOutput("fetch_if_ack", if_ack, 1'b1);
    checkOutput("fetch_if_rdata", if_rdata, 32'hDEADBEEF);
    nextCycle();
    if_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("idle_ready_req", mem_req, 1'b0);
      checkOutput("idle_ready_ack", if_ack || d_ack, 1'b0);
      checkOutput("idle_ready_addr", mem_addr, 32'h0);
      nextCycle();
    end

    // Both requesting with memory always ready: strict alternation starting with fetch.
    doReset();
    applyStimulus(1, 32'h200, 1, 0, 32'h300, 0, 3'b010, 1, 32'h11110000);
    @(negedge clk);
    checkOutput("rr_idle_acks", if_ack || d_ack, 1'b0);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      mem_rdata = 32'h11110000 + k;
      if (k == 4) d_req = 1'b0;
      @(negedge clk);
      checkOutput("rr_if_ack", if_ack, (k % 2) == 0);
      checkOutput("rr_d_ack", d_ack, (k % 2) == 1);
      checkOutput("rr_mem_addr", mem_addr, ((k % 2) == 0) ? 32'h200 : 32'h300);
    end
    nextCycle();
    if_req = 1'b0;
    mem_ready = 1'b0;
    nextCycle();

    // Store with memory answering on the fourth busy cycle.
    applyStimulus(0, 0, 1, 1, 32'h10, 32'h55, 3'b000, 0, 32'h0000AAAA);
    @(negedge clk);
    checkOutput("st_idle_req", mem_req, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      if (k == 4) mem_ready = 1'b1;
      @(negedge clk);
      checkOutput("st_mem_req", mem_req, 1'b1);
      checkOutput("st_mem_we", mem_we, 1'b1);
      checkOutput("st_mem_addr", mem_addr, 32'h10);
      checkOutput("st_mem_wdata", mem_wdata, 32'h55);
      checkOutput("st_mem_width", mem_width, 3'b000);
      checkOutput("st_d_ack", d_ack, k == 4);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    nextCycle();

    // Reset in the middle of a data access abandons it.
    applyStimulus(0, 0, 1, 0, 32'h20, 0, 3'b010, 0, 32'h12345678);
    nextCycle();
    @(negedge clk);
    checkOutput("rmid_busy_req", mem_req, 1'b1);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rmid_req_dropped", mem_req, 1'b0);
    checkOutput("rmid_no_ack", d_ack, 1'b0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rmid_idle_after", mem_req, 1'b0);
    nextCycle();
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("rmid_reissue_ack", d_ack, 1'b1);
    checkOutput("rmid_reissue_rdata", d_rdata, 32'h12345678);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 3'b000, 0, 0);
    nextCycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: the fourth busy cycle completes with an error.
    doReset();
    applyStimulus(0, 0, 1, 0, 32'h40, 0, 3'b010, 0, 32'hCAFEF00D);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("to_mem_req", mem_req, k < 4);
      checkOutput("to_d_ack", d_ack, k == 4);
      checkOutput("to_d_err", d_err, k == 4);
      checkOutput("to_d_rdata", d_rdata, 32'h0);
    end
    nextCycle();
    d_req = 1'b0;
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("to_sticky", timeout_err, 1'b1);
    doReset();
    @(negedge clk);
    checkOutput("to_cleared", timeout_err, 1'b0);
    nextCycle();
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sawIf = if_ack;
      sawD  = d_ack;
      nextCycle();
      reset = ($urandom_range(0, 99) == 0);
      if (!if_req || sawIf) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!d_req || sawD) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_width = 3'($urandom_range(0, 7));
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
